// File: rtl/clock_divider_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_multi_if
// Purpose  : Control / status bundle for clock_divider_multi.
//            master = controller side (drives enables, sync, loads),
//            slave  = divider side (drives divided clocks, ticks, load_err).
// Signals  : en[NUM_CH]     per-channel count enable
//            sync           restart all channels phase-aligned
//            load_valid     half-period load strobe
//            load_ch        target channel of the load
//            load_val[CNT_W] new half-period value
//            clkout[NUM_CH] divided square waves
//            tick[NUM_CH]   one-cycle pulse on every clkout edge
//            load_err       pulse after a load to a non-existent channel
// Revision : 1.0 - initial release
// ============================================================================
interface clock_divider_multi_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] en;
   logic              sync;
   logic              load_valid;
   logic [CH_W-1:0]   load_ch;
   logic [CNT_W-1:0]  load_val;
   logic [NUM_CH-1:0] clkout;
   logic [NUM_CH-1:0] tick;
   logic              load_err;

   modport master (
      output en, sync, load_valid, load_ch, load_val,
      input  clkout, tick, load_err
   );

   modport slave (
      input  en, sync, load_valid, load_ch, load_val,
      output clkout, tick, load_err
   );
endinterface
`default_nettype wire

// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_multi
// Purpose  : NUM_CH independent clock dividers sharing one system clock.
//            Each channel counts 0..hp and toggles its output when the count
//            reaches hp, giving a period of 2*(hp+1) clkin cycles.
// Ports    : clkin   system clock, all logic on its rising edge
//            reset   synchronous active-high reset
//            bus     clock_divider_multi_if.slave (enables, sync, load
//                    strobe/channel/value in; clkout, tick, load_err out)
// Priority : reset > sync > load > count
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_multi #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 16,
   parameter int DEFAULT_HALF = 50000
) (
   input wire logic               clkin,
   input wire logic               reset,
   clock_divider_multi_if.slave   bus
);
   localparam logic [CNT_W-1:0] C_DEFAULT_HALF = CNT_W'(DEFAULT_HALF);

   logic [NUM_CH-1:0] w_clkout;
   logic [NUM_CH-1:0] w_tick;
   logic              w_load_ok;
   logic              r_load_err;

   // load_ch may be wide enough to name channels that do not exist
   // (NUM_CH not a power of two); such loads are rejected.
   assign w_load_ok = int'(bus.load_ch) < NUM_CH;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_hp;
      logic             r_out;
      logic             r_tick;
      logic             w_load_hit;

      assign w_load_hit = bus.load_valid && w_load_ok && (int'(bus.load_ch) == i);

      always_ff @(posedge clkin) begin
         if (reset) begin
            r_cnt  <= '0;
            r_hp   <= C_DEFAULT_HALF;
            r_out  <= 1'b0;
            r_tick <= 1'b0;
         end else begin
            // hp is written even when sync clears the channel in the same cycle
            if (w_load_hit) begin
               r_hp <= bus.load_val;
            end
            if (bus.sync || w_load_hit) begin
               r_cnt  <= '0;
               r_out  <= 1'b0;
               r_tick <= 1'b0;
            end else if (bus.en[i]) begin
               if (r_cnt == r_hp) begin
                  r_cnt  <= '0;
                  r_out  <= ~r_out;
                  r_tick <= 1'b1;
               end else begin
                  r_cnt  <= r_cnt + 1'b1;
                  r_tick <= 1'b0;
               end
            end else begin
               r_tick <= 1'b0;
            end
         end
      end

      assign w_clkout[i] = r_out;
      assign w_tick[i]   = r_tick;
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         r_load_err <= 1'b0;
      end else begin
         r_load_err <= bus.load_valid && !w_load_ok;
      end
   end

   assign bus.clkout   = w_clkout;
   assign bus.tick     = w_tick;
   assign bus.load_err = r_load_err;
endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_multi
// Purpose  : Directed self-checking bench for clock_divider_multi.
//            u_dut4: NUM_CH=4, DEFAULT_HALF=3 (main scenarios).
//            u_dut3: NUM_CH=3, so load_ch=3 is a representable invalid channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_multi;
   logic clkin;
   logic reset;

   clock_divider_multi_if #(.NUM_CH(4), .CNT_W(16)) bus4 ();
   clock_divider_multi_if #(.NUM_CH(3), .CNT_W(8))  bus3 ();

   clock_divider_multi #(.NUM_CH(4), .CNT_W(16), .DEFAULT_HALF(3)) u_dut4 (
      .clkin (clkin),
      .reset (reset),
      .bus   (bus4.slave)
   );

   clock_divider_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_HALF(3)) u_dut3 (
      .clkin (clkin),
      .reset (reset),
      .bus   (bus3.slave)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle away from it.
   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   // Phase tables: index 0 is the first edge of the phase.
   logic [3:0]  p2_out [8] = '{4'hD, 4'hF, 4'hD, 4'h2, 4'h0, 4'h2, 4'h0, 4'hF};
   logic [3:0]  p2_tick[8] = '{4'h0, 4'h2, 4'h2, 4'hF, 4'h2, 4'h2, 4'h2, 4'hF};
   logic [14:0] p3_out     = 15'b011111100000011;
   logic [14:0] p3_tick    = 15'b100000100000000;
   logic [3:0]  p5_out [7] = '{4'h0, 4'h2, 4'h8, 4'hA, 4'h1, 4'h3, 4'hD};
   logic [3:0]  p5_tick[7] = '{4'h0, 4'h2, 4'hA, 4'h2, 4'hB, 4'h2, 4'hE};

   initial begin
      reset           = 1'b1;
      bus4.en         = '0;
      bus4.sync       = 1'b0;
      bus4.load_valid = 1'b0;
      bus4.load_ch    = '0;
      bus4.load_val   = '0;
      bus3.en         = '0;
      bus3.sync       = 1'b0;
      bus3.load_valid = 1'b0;
      bus3.load_ch    = '0;
      bus3.load_val   = '0;

      step();
      step();
      check_eq("rst_clkout",   32'(bus4.clkout),   32'h0);
      check_eq("rst_tick",     32'(bus4.tick),     32'h0);
      check_eq("rst_load_err", 32'(bus4.load_err), 32'h0);

      // Defaults (hp=3): toggle at edges 4, 8, 12
      reset   = 1'b0;
      bus4.en = 4'hF;
      bus3.en = 3'h7;
      for (int k = 1; k <= 12; k++) begin
         step();
         check_eq($sformatf("p1_out_e%0d", k),  32'(bus4.clkout), ((k / 4) % 2 == 1) ? 32'hF : 32'h0);
         check_eq($sformatf("p1_tick_e%0d", k), 32'(bus4.tick),   (k % 4 == 0) ? 32'hF : 32'h0);
      end

      // Load ch1 with hp=0 while the others keep running
      for (int k = 13; k <= 20; k++) begin
         bus4.load_valid = (k == 13);
         bus4.load_ch    = 2'd1;
         bus4.load_val   = 16'd0;
         step();
         check_eq($sformatf("p2_out_e%0d", k),  32'(bus4.clkout), 32'(p2_out[k-13]));
         check_eq($sformatf("p2_tick_e%0d", k), 32'(bus4.tick),   32'(p2_tick[k-13]));
      end
      bus4.load_valid = 1'b0;

      // Load ch2 with hp=5 while clkout[2]=1 mid-period
      for (int k = 21; k <= 35; k++) begin
         bus4.load_valid = (k == 23);
         bus4.load_ch    = 2'd2;
         bus4.load_val   = 16'd5;
         step();
         check_eq($sformatf("p3_out2_e%0d", k),  32'(bus4.clkout[2]), 32'(p3_out[k-21]));
         check_eq($sformatf("p3_tick2_e%0d", k), 32'(bus4.tick[2]),   32'(p3_tick[k-21]));
      end
      bus4.load_valid = 1'b0;

      // Freeze ch0 for 7 edges at cnt=2
      for (int k = 36; k <= 47; k++) begin
         bus4.en = (k >= 39 && k <= 45) ? 4'hE : 4'hF;
         step();
         check_eq($sformatf("p4_out0_e%0d", k),  32'(bus4.clkout[0]), (k < 47) ? 32'h1 : 32'h0);
         check_eq($sformatf("p4_tick0_e%0d", k), 32'(bus4.tick[0]),   (k == 36 || k == 47) ? 32'h1 : 32'h0);
      end
      bus4.en = 4'hF;

      // Sync together with a load of ch3 (hp=1)
      for (int k = 48; k <= 54; k++) begin
         bus4.sync       = (k == 48);
         bus4.load_valid = (k == 48);
         bus4.load_ch    = 2'd3;
         bus4.load_val   = 16'd1;
         step();
         check_eq($sformatf("p5_out_e%0d", k),  32'(bus4.clkout), 32'(p5_out[k-48]));
         check_eq($sformatf("p5_tick_e%0d", k), 32'(bus4.tick),   32'(p5_tick[k-48]));
         if (k == 48) check_eq("p5_no_load_err", 32'(bus4.load_err), 32'h0);
      end
      bus4.sync       = 1'b0;
      bus4.load_valid = 1'b0;

      // Invalid channel on the 3-channel instance (edge 55)
      bus3.load_valid = 1'b1;
      bus3.load_ch    = 2'd3;
      bus3.load_val   = 8'd9;
      step();
      check_eq("err_pulse",      32'(bus3.load_err), 32'h1);
      check_eq("err_clkout_e55", 32'(bus3.clkout),   32'h7);
      bus3.load_valid = 1'b0;
      step();
      check_eq("err_clear",      32'(bus3.load_err), 32'h0);
      check_eq("err_clkout_e56", 32'(bus3.clkout),   32'h0);
      check_eq("err_tick_e56",   32'(bus3.tick),     32'h7);

      // Reset while a load is presented: reset wins, hp returns to default
      reset           = 1'b1;
      bus4.load_valid = 1'b1;
      bus4.load_ch    = 2'd0;
      bus4.load_val   = 16'd1;
      step();
      check_eq("rl_clkout",   32'(bus4.clkout),   32'h0);
      check_eq("rl_tick",     32'(bus4.tick),     32'h0);
      check_eq("rl_load_err", 32'(bus4.load_err), 32'h0);
      reset           = 1'b0;
      bus4.load_valid = 1'b0;
      step();
      step();
      check_eq("rl_out_e2", 32'(bus4.clkout), 32'h0);
      step();
      step();
      check_eq("rl_out_e4",  32'(bus4.clkout), 32'hF);
      check_eq("rl_tick_e4", 32'(bus4.tick),   32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
